// File: rtl/spmv_sram_port_arbiter_pkg.sv
// Shared definitions for the SpMV SRAM port arbiter: SRAM geometry, requester IDs
// and the lock FSM state encoding.
package spmv_sram_port_arbiter_pkg;

    localparam int DATA_LEN    = 32;
    localparam int N           = 8;
    localparam int SRAM_DATA_W = DATA_LEN * N;
    localparam int SRAM_ADDR_W = 4;

    localparam int REQ_A       = 0;
    localparam int REQ_BVEC    = 1;
    localparam int REQ_WB      = 2;
    localparam int NUM_REQ_DEF = 3;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } lockState_e;

endpackage

// File: rtl/spmv_sram_port_arbiter_rr_pick.sv
// One-hot round-robin picker: grants the first requesting index at or after the
// pointer, wrapping around. Purely combinational.
module rr_priority_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    int   idx;
    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spmv_sram_port_arbiter.sv
// Shares one single-port SRAM among NUM_REQ requesters: round-robin grant with a
// bounded burst lock, registered SRAM command and tagged read-data return.
module spmv_sram_port_arbiter
    import spmv_sram_port_arbiter_pkg::*;
#(
    parameter int  NUM_REQ  = NUM_REQ_DEF,
    parameter int  DATA_W   = SRAM_DATA_W,
    parameter int  ADDR_W   = SRAM_ADDR_W,
    parameter int  RD_LAT   = 1,
    parameter int  MAX_LOCK = 8,
    localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ-1:0]          i_we,
    input  logic [NUM_REQ-1:0]          i_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   i_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   i_wdata,
    output logic [NUM_REQ-1:0]          o_gnt,
    output logic [NUM_REQ-1:0]          o_rvalid,
    output logic [DATA_W-1:0]           o_rdata,
    output logic [ADDR_W-1:0]           o_sram_address,
    output logic                        o_sram_write,
    output logic [DATA_W-1:0]           o_sram_writedata,
    input  logic [DATA_W-1:0]           i_sram_readdata,
    output logic [PTR_W-1:0]            o_owner,
    output logic                        o_busy
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    lockState_e               state_q, state_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [PTR_W-1:0]         owner_q, owner_d;
    logic [CNT_W-1:0]         lockCnt_q, lockCnt_d;
    logic [NUM_REQ-1:0]       rrGnt;
    logic [NUM_REQ-1:0]       gnt;
    logic [PTR_W-1:0]         gntIdx;
    logic                     anyGnt;
    logic                     lockActive;
    logic                     rdAccept;
    logic [ADDR_W-1:0]        sramAddr_q;
    logic                     sramWrite_q;
    logic [DATA_W-1:0]        sramWdata_q;
    logic [RD_LAT:0]          tagVld_q;
    logic [RD_LAT:0][PTR_W-1:0] tagId_q;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i (i_req),
        .ptr_i (ptr_q),
        .gnt_o (rrGnt)
    );

    // A locked owner that stops requesting releases immediately, so the others
    // are arbitrated in the same cycle.
    assign lockActive = (state_q == ST_LOCKED) && i_req[owner_q];

    always_comb begin
        gnt = '0;
        if (i_rstn) begin
            if (lockActive) begin
                gnt[owner_q] = 1'b1;
            end else begin
                gnt = rrGnt;
            end
        end
    end

    always_comb begin
        gntIdx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                gntIdx = PTR_W'(k);
            end
        end
    end

    assign anyGnt   = |gnt;
    assign rdAccept = anyGnt && !i_we[gntIdx];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        lockCnt_d = lockCnt_q;
        if (anyGnt) begin
            ptr_d   = (gntIdx == PTR_W'(NUM_REQ - 1)) ? '0 : gntIdx + 1'b1;
            owner_d = gntIdx;
        end
        if (lockActive) begin
            if (!i_lock[owner_q] || lockCnt_q == CNT_W'(MAX_LOCK - 1)) begin
                state_d   = ST_IDLE;
                lockCnt_d = '0;
            end else begin
                lockCnt_d = lockCnt_q + 1'b1;
            end
        end else begin
            state_d   = ST_IDLE;
            lockCnt_d = '0;
            if (anyGnt && i_lock[gntIdx] && MAX_LOCK > 1) begin
                state_d   = ST_LOCKED;
                lockCnt_d = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            lockCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            lockCnt_q <= lockCnt_d;
        end
    end

    // Address and write data hold their last value between beats.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sramAddr_q  <= '0;
            sramWrite_q <= 1'b0;
            sramWdata_q <= '0;
        end else begin
            sramWrite_q <= anyGnt && i_we[gntIdx];
            if (anyGnt) begin
                sramAddr_q  <= i_addr[int'(gntIdx)*ADDR_W +: ADDR_W];
                sramWdata_q <= i_wdata[int'(gntIdx)*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tagVld_q <= '0;
            tagId_q  <= '0;
        end else begin
            tagVld_q <= {tagVld_q[RD_LAT-1:0], rdAccept};
            tagId_q  <= {tagId_q[RD_LAT-1:0], gntIdx};
        end
    end

    always_comb begin
        o_rvalid = '0;
        if (tagVld_q[RD_LAT]) begin
            o_rvalid[tagId_q[RD_LAT]] = 1'b1;
        end
    end

    assign o_rdata          = tagVld_q[RD_LAT] ? i_sram_readdata : '0;
    assign o_gnt            = gnt;
    assign o_sram_address   = sramAddr_q;
    assign o_sram_write     = sramWrite_q;
    assign o_sram_writedata = sramWdata_q;
    assign o_owner          = owner_q;
    assign o_busy           = (state_q == ST_LOCKED) || (|tagVld_q);

endmodule

// File: tb/tb_spmv_sram_port_arbiter.sv
// Directed scoreboard bench: grants are checked cycle by cycle, read returns are
// queued at issue and matched by a separate monitor against a behavioural SRAM.
module tb_spmv_sram_port_arbiter;
    import spmv_sram_port_arbiter_pkg::*;

    localparam int NR = 3;
    localparam int DW = 256;
    localparam int AW = 4;
    localparam int PW = 2;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic              i_clk;
    logic              i_rstn;
    logic [NR-1:0]     i_req;
    logic [NR-1:0]     i_we;
    logic [NR-1:0]     i_lock;
    logic [NR*AW-1:0]  i_addr;
    logic [NR*DW-1:0]  i_wdata;
    logic [NR-1:0]     o_gnt;
    logic [NR-1:0]     o_rvalid;
    logic [DW-1:0]     o_rdata;
    logic [AW-1:0]     o_sram_address;
    logic              o_sram_write;
    logic [DW-1:0]     o_sram_writedata;
    logic [DW-1:0]     i_sram_readdata;
    logic [PW-1:0]     o_owner;
    logic              o_busy;

    exp_t          expQ[$];
    exp_t          monE;
    int            vectors;
    int            miscompares;
    int            cycleCnt;
    int            rvCount[NR];
    logic [DW-1:0] refMem[16];
    logic [DW-1:0] memWr[16];
    logic          memVal[16];
    logic          memClear;
    logic [DW-1:0] rdQ;

    spmv_sram_port_arbiter #(
        .NUM_REQ  (NR),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .RD_LAT   (1),
        .MAX_LOCK (8)
    ) dut (
        .i_clk            (i_clk),
        .i_rstn           (i_rstn),
        .i_req            (i_req),
        .i_we             (i_we),
        .i_lock           (i_lock),
        .i_addr           (i_addr),
        .i_wdata          (i_wdata),
        .o_gnt            (o_gnt),
        .o_rvalid         (o_rvalid),
        .o_rdata          (o_rdata),
        .o_sram_address   (o_sram_address),
        .o_sram_write     (o_sram_write),
        .o_sram_writedata (o_sram_writedata),
        .i_sram_readdata  (i_sram_readdata),
        .o_owner          (o_owner),
        .o_busy           (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cycleCnt <= cycleCnt + 1;

    // Power-on SRAM contents: word a holds byte {A, a} repeated, e.g. word 5 = A5A5...
    function automatic logic [DW-1:0] initPat(input int a);
        logic [7:0] b;
        b = {4'hA, 4'(a)};
        return {32{b}};
    endfunction

    // Single-port SRAM, one cycle read latency, read-before-write on the same edge.
    always @(posedge i_clk) begin
        if (memClear) begin
            for (int a = 0; a < 16; a++) begin
                memVal[a] <= 1'b0;
            end
        end else if (o_sram_write) begin
            memWr[o_sram_address]  <= o_sram_writedata;
            memVal[o_sram_address] <= 1'b1;
        end
        rdQ <= memVal[o_sram_address] ? memWr[o_sram_address] : initPat(int'(o_sram_address));
    end
    assign i_sram_readdata = rdQ;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setPort(input int k, input int a, input logic [DW-1:0] wd);
        i_addr[k*AW +: AW]  = AW'(a);
        i_wdata[k*DW +: DW] = wd;
    endtask

    task automatic stepEdge();
        @(posedge i_clk);
        #1;
    endtask

    // Drives one cycle of commands, checks the grant mid-cycle and records the
    // expected effect of the accepted beat on the reference memory / return queue.
    task automatic applyStimulus(input logic [NR-1:0] req, input logic [NR-1:0] we,
                                 input logic [NR-1:0] lock, input logic [NR-1:0] expGnt,
                                 input string name);
        exp_t e;
        int   a;
        i_req  = req;
        i_we   = we;
        i_lock = lock;
        @(negedge i_clk);
        checkOutput(name, DW'(o_gnt), DW'(expGnt));
        for (int k = 0; k < NR; k++) begin
            if (expGnt[k]) begin
                a = int'(i_addr[k*AW +: AW]);
                if (we[k]) begin
                    refMem[a] = i_wdata[k*DW +: DW];
                end else begin
                    e.id   = k;
                    e.data = refMem[a];
                    e.cyc  = cycleCnt + 2;
                    expQ.push_back(e);
                end
            end
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, "idle gnt");
            stepEdge();
        end
    endtask

    always @(negedge i_clk) begin
        if (o_rvalid != '0) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected rvalid: got rvalid %b expected none", o_rvalid);
            end else begin
                monE = expQ.pop_front();
                rvCount[monE.id]++;
                if (o_rvalid !== NR'(1 << monE.id) || o_rdata !== monE.data || cycleCnt != monE.cyc) begin
                    miscompares++;
                    $display("[TB] FAIL read return: got rvalid %b data %0h cycle %0d expected rvalid %b data %0h cycle %0d",
                             o_rvalid, o_rdata, cycleCnt, NR'(1 << monE.id), monE.data, monE.cyc);
                end
            end
        end else if (expQ.size() != 0 && expQ[0].cyc <= cycleCnt) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL missing rvalid: got none expected requester %0d at cycle %0d",
                     expQ[0].id, expQ[0].cyc);
            monE = expQ.pop_front();
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_rstn   = 1'b0;
        memClear = 1'b1;
        i_req    = 3'b111;
        i_we     = '0;
        i_lock   = '0;
        i_addr   = '0;
        i_wdata  = '0;
        for (int a = 0; a < 16; a++) begin
            refMem[a] = initPat(a);
        end
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("reset gnt", DW'(o_gnt), '0);
        checkOutput("reset rvalid", DW'(o_rvalid), '0);
        checkOutput("reset rdata", o_rdata, '0);
        checkOutput("reset sram addr", DW'(o_sram_address), '0);
        checkOutput("reset sram write", DW'(o_sram_write), '0);
        checkOutput("reset sram wdata", o_sram_writedata, '0);
        checkOutput("reset owner", DW'(o_owner), '0);
        checkOutput("reset busy", DW'(o_busy), '0);
        i_req    = '0;
        memClear = 1'b0;
        i_rstn   = 1'b1;
        idleCycles(1);

        $display("[TB] T1 reset during read");
        setPort(REQ_BVEC, 5, '0);
        applyStimulus(3'b010, 3'b000, 3'b000, 3'b010, "T1 grant");
        stepEdge();
        i_req = 3'b111;
        #2;
        i_rstn = 1'b0;
        #1;
        checkOutput("T1 gnt in reset", DW'(o_gnt), '0);
        checkOutput("T1 addr in reset", DW'(o_sram_address), '0);
        checkOutput("T1 busy in reset", DW'(o_busy), '0);
        checkOutput("T1 rvalid in reset", DW'(o_rvalid), '0);
        expQ.delete();
        i_req = '0;
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            checkOutput("T1 no flushed rvalid", DW'(o_rvalid), '0);
            stepEdge();
        end

        $display("[TB] T2 round robin");
        for (int k = 0; k < NR; k++) rvCount[k] = 0;
        setPort(REQ_A, 1, '0);
        setPort(REQ_BVEC, 2, '0);
        setPort(REQ_WB, 4, '0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(3'b111, 3'b000, 3'b000, NR'(3'b001 << (i % 3)), "T2 rr gnt");
            stepEdge();
        end
        idleCycles(3);
        for (int k = 0; k < NR; k++) begin
            checkOutput("T2 rvalid count", DW'(rvCount[k]), DW'(3));
        end

        $display("[TB] T3 read latency");
        setPort(REQ_BVEC, 5, '0);
        applyStimulus(3'b010, 3'b000, 3'b000, 3'b010, "T3 grant");
        stepEdge();
        i_req = '0;
        @(negedge i_clk);
        checkOutput("T3 sram addr", DW'(o_sram_address), DW'(5));
        checkOutput("T3 sram write", DW'(o_sram_write), '0);
        checkOutput("T3 early rvalid", DW'(o_rvalid), '0);
        stepEdge();
        @(negedge i_clk);
        checkOutput("T3 rvalid", DW'(o_rvalid), DW'(3'b010));
        checkOutput("T3 rdata", o_rdata, {32{8'hA5}});
        stepEdge();
        idleCycles(1);

        $display("[TB] T4 lock cap");
        setPort(REQ_WB, 7, '0);
        applyStimulus(3'b100, 3'b000, 3'b000, 3'b100, "T4 pointer setup");
        stepEdge();
        setPort(REQ_A, 6, '0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'b101, 3'b000, 3'b001, 3'b001, "T4 locked gnt");
            if (i == 3) checkOutput("T4 busy locked", DW'(o_busy), DW'(1));
            stepEdge();
        end
        applyStimulus(3'b101, 3'b000, 3'b001, 3'b100, "T4 forced release gnt");
        checkOutput("T4 owner", DW'(o_owner), DW'(0));
        stepEdge();
        idleCycles(3);
        checkOutput("T4 owner after", DW'(o_owner), DW'(2));
        checkOutput("T4 busy after", DW'(o_busy), '0);

        $display("[TB] T5 write then read");
        setPort(REQ_WB, 3, 256'hDEAD);
        applyStimulus(3'b100, 3'b100, 3'b000, 3'b100, "T5 write gnt");
        stepEdge();
        setPort(REQ_A, 3, '0);
        applyStimulus(3'b001, 3'b000, 3'b000, 3'b001, "T5 read gnt");
        checkOutput("T5 write pulse", DW'(o_sram_write), DW'(1));
        checkOutput("T5 write addr", DW'(o_sram_address), DW'(3));
        checkOutput("T5 write data", o_sram_writedata, 256'hDEAD);
        stepEdge();
        applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, "T5 idle gnt");
        checkOutput("T5 write pulse end", DW'(o_sram_write), '0);
        checkOutput("T5 read addr", DW'(o_sram_address), DW'(3));
        stepEdge();
        applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, "T5 idle gnt");
        checkOutput("T5 rvalid", DW'(o_rvalid), DW'(3'b001));
        checkOutput("T5 rdata", o_rdata, 256'hDEAD);
        stepEdge();
        idleCycles(1);

        $display("[TB] T6 owner drops request");
        setPort(REQ_A, 8, '0);
        setPort(REQ_BVEC, 9, '0);
        applyStimulus(3'b001, 3'b000, 3'b001, 3'b001, "T6 lock gnt");
        stepEdge();
        applyStimulus(3'b011, 3'b000, 3'b001, 3'b001, "T6 masked gnt");
        checkOutput("T6 busy locked", DW'(o_busy), DW'(1));
        stepEdge();
        applyStimulus(3'b010, 3'b000, 3'b000, 3'b010, "T6 drop gnt");
        stepEdge();
        applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, "T6 idle gnt");
        checkOutput("T6 busy inflight", DW'(o_busy), DW'(1));
        stepEdge();
        applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, "T6 idle gnt");
        checkOutput("T6 last rvalid", DW'(o_rvalid), DW'(3'b010));
        checkOutput("T6 busy at rvalid", DW'(o_busy), DW'(1));
        stepEdge();
        applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, "T6 idle gnt");
        checkOutput("T6 busy falls", DW'(o_busy), '0);
        stepEdge();

        idleCycles(2);
        checkOutput("queue drained", DW'(expQ.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
